// File: rtl/minv_mdiv_gen.sv
// Modular inverse / modular division engine (binary extended Euclid), word-serial load and unload.
// Optional RUN-cycle watchdog compiled in when MINV_MDIV_GEN_WDOG_EN is defined.
module minv_mdiv_gen #(
    parameter int unsigned OPW  = 256,
    parameter int unsigned BUSW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [BUSW-1:0] in_data,
    input  logic            mode,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BUSW-1:0] out_data,
    output logic            out_last
);
    localparam int unsigned NW = OPW / BUSW;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
`ifdef MINV_MDIV_GEN_WDOG_EN
    localparam int unsigned WD_LIM = 4 * OPW + 3;
    localparam int unsigned WDW    = $clog2(4 * OPW + 4);
`endif

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [OPW-1:0]  a_q, b_q, p_q, u_q, v_q, x1_q, x2_q, res_q;
    logic [OPW-1:0]  a_d, b_d, p_d, u_d, v_d, x1_d, x2_d, res_d;
    logic [OPW-1:0]  res_sh;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            in_ready_d, busy_d, done_d, err_d, out_valid_d, out_last_d;
    logic [BUSW-1:0] out_data_d;
`ifdef MINV_MDIV_GEN_WDOG_EN
    logic [WDW-1:0]  wd_q, wd_d;
`endif

    // Halve x modulo odd m; the OPW+1-bit sum keeps its carry as the new MSB.
    function automatic logic [OPW-1:0] mod_half(input logic [OPW-1:0] x, input logic [OPW-1:0] m);
        logic [OPW:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[OPW:1];
    endfunction

    function automatic logic [OPW-1:0] mod_sub(input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                                               input logic [OPW-1:0] m);
        logic [OPW:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[OPW] ? (d[OPW-1:0] + m) : d[OPW-1:0];
    endfunction

    assign res_sh = res_q >> BUSW;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        u_d         = u_q;
        v_d         = v_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        res_d       = res_q;
        wcnt_d      = wcnt_q;
        done_d      = 1'b0;
        err_d       = err;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
`ifdef MINV_MDIV_GEN_WDOG_EN
        wd_d        = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    case (in_sel)
                        2'b00:   a_d = OPW'({in_data, a_q} >> BUSW);
                        2'b01:   b_d = OPW'({in_data, b_q} >> BUSW);
                        2'b10:   p_d = OPW'({in_data, p_q} >> BUSW);
                        default: ;
                    endcase
                end
                if (start) begin
                    err_d   = 1'b0;
                    u_d     = a_q;
                    v_d     = p_q;
                    x1_d    = mode ? OPW'(1) : b_q;
                    x2_d    = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef MINV_MDIV_GEN_WDOG_EN
                wd_d = '0;
`endif
                if (!v_q[0] || v_q < OPW'(3) || u_q == '0 || u_q >= v_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (u_q == OPW'(1)) begin
                    res_d   = x1_q;
                    done_d  = 1'b1;
                    state_d = S_OUT;
                end else if (v_q == OPW'(1)) begin
                    res_d   = x2_q;
                    done_d  = 1'b1;
                    state_d = S_OUT;
                end else if (u_q == '0 || v_q == '0) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = mod_half(x1_q, p_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = mod_half(x2_q, p_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = mod_sub(x1_q, x2_q, p_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = mod_sub(x2_q, x1_q, p_q);
                end
`ifdef MINV_MDIV_GEN_WDOG_EN
                // Runaway guard: overrides whatever the datapath chose this cycle.
                wd_d = wd_q + WDW'(1);
                if (wd_q == WDW'(WD_LIM - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_OUT: begin
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q[BUSW-1:0];
                    out_last_d  = (NW == 1);
                    wcnt_d      = '0;
                end else if (out_ready) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        state_d     = S_IDLE;
                    end else begin
                        res_d      = res_sh;
                        out_data_d = res_sh[BUSW-1:0];
                        wcnt_d     = wcnt_q + CW'(1);
                        out_last_d = (wcnt_q == CW'(NW - 2));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            res_q     <= '0;
            wcnt_q    <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
`ifdef MINV_MDIV_GEN_WDOG_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            u_q       <= u_d;
            v_q       <= v_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            res_q     <= res_d;
            wcnt_q    <= wcnt_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
`ifdef MINV_MDIV_GEN_WDOG_EN
            wd_q      <= wd_d;
`endif
        end
    end
endmodule

// File: tb/tb_minv_mdiv_gen.sv
// Scoreboard bench for minv_mdiv_gen: a 16/8-bit instance for most cases and a 256/32-bit P-256 case.
module tb_minv_mdiv_gen;
    localparam int unsigned SOP = 16;
    localparam int unsigned SW  = 8;
    localparam int unsigned SNW = SOP / SW;
    localparam int unsigned LOP = 256;
    localparam int unsigned LW  = 32;
    localparam int unsigned LNW = LOP / LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          s_in_valid, s_in_ready, s_mode, s_start, s_busy, s_done, s_err;
    logic          s_out_valid, s_out_ready, s_out_last;
    logic [1:0]    s_in_sel;
    logic [SW-1:0] s_in_data, s_out_data;
    logic          l_in_valid, l_in_ready, l_mode, l_start, l_busy, l_done, l_err;
    logic          l_out_valid, l_out_ready, l_out_last;
    logic [1:0]    l_in_sel;
    logic [LW-1:0] l_in_data, l_out_data;

    minv_mdiv_gen #(.OPW(SOP), .BUSW(SW)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sel(s_in_sel),
        .in_data(s_in_data), .mode(s_mode), .start(s_start), .busy(s_busy), .done(s_done),
        .err(s_err), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last));

    minv_mdiv_gen #(.OPW(LOP), .BUSW(LW)) dut_l (
        .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_sel(l_in_sel),
        .in_data(l_in_data), .mode(l_mode), .start(l_start), .busy(l_busy), .done(l_done),
        .err(l_err), .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_last(l_out_last));

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t q_s[$];
    exp_t q_l[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   s_rdy_mode = 0;
    logic s_ov_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: b * a^-1 mod p via signed extended Euclid.
    function automatic longint mod_div(input longint a, input longint b, input longint p);
        longint t, nt, r, nr, q, tmp;
        t = 0; nt = 1; r = p; nr = a;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + p;
        return (t * b) % p;
    endfunction

    always @(posedge clk) begin
        #1;
        if (s_rdy_mode == 1) s_out_ready = ~s_out_ready;
        else                 s_out_ready = 1'b1;
    end

    logic          s_hold_pend, s_done_prev, s_last_prev;
    logic [SW-1:0] s_hold_data;
    always @(negedge clk) begin
        if (rst) begin
            s_hold_pend = 1'b0;
            s_done_prev = 1'b0;
            s_last_prev = 1'b0;
        end else begin
            if (s_hold_pend && s_out_valid) check("s_hold", 64'(s_out_data), 64'(s_hold_data));
            if (s_done_prev && !s_err) check("s_ov_after_done", 64'(s_out_valid), 64'(1));
            if (s_last_prev) check("s_ready_after_last", 64'(s_in_ready), 64'(1));
            s_done_prev = s_done;
            s_hold_pend = s_out_valid && !s_out_ready;
            s_hold_data = s_out_data;
            s_last_prev = s_out_valid && s_out_ready && s_out_last;
            if (s_out_valid) s_ov_seen = 1'b1;
            if (s_out_valid && s_out_ready) begin
                check("s_beat_expected", 64'(q_s.size() != 0), 64'(1));
                if (q_s.size() != 0) begin
                    exp_t e;
                    e = q_s.pop_front();
                    check("s_data", 64'(s_out_data), 64'(e.data));
                    check("s_last", 64'(s_out_last), 64'(e.last));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && l_out_valid && l_out_ready) begin
            check("l_beat_expected", 64'(q_l.size() != 0), 64'(1));
            if (q_l.size() != 0) begin
                exp_t e;
                e = q_l.pop_front();
                check("l_data", 64'(l_out_data), 64'(e.data));
                check("l_last", 64'(l_out_last), 64'(e.last));
            end
        end
    end

    task automatic load_s(input logic [1:0] sel, input logic [SOP-1:0] val);
        for (int w = 0; w < int'(SNW); w++) begin
            s_in_sel = sel; s_in_data = val[w*SW +: SW]; s_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic load_l(input logic [1:0] sel, input logic [LOP-1:0] val);
        for (int w = 0; w < int'(LNW); w++) begin
            l_in_sel = sel; l_in_data = val[w*LW +: LW]; l_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        l_in_valid = 1'b0;
    endtask

    task automatic start_s(input string tag, input logic m, input int a, input int b, input int p);
        load_s(2'd0, 16'(a));
        load_s(2'd1, 16'(b));
        load_s(2'd2, 16'(p));
        s_in_sel = 2'd3; s_in_data = 8'hA5; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_ov_seen = 1'b0;
        s_mode = m; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, 64'({s_busy, s_in_ready}), 64'(2'b10));
    endtask

    task automatic run_s(input string tag, input logic m, input int a, input int b, input int p,
                         input logic exp_err, input int exp_lat);
        int   lat;
        logic got_done;
        longint res;
        if (!exp_err) begin
            res = m ? mod_div(longint'(a), 1, longint'(p)) : mod_div(longint'(a), longint'(b), longint'(p));
            for (int w = 0; w < int'(SNW); w++)
                q_s.push_back('{data: 32'((res >> (w * SW)) & 8'hFF), last: (w == int'(SNW) - 1)});
        end
        start_s(tag, m, a, b, p);
        lat = 1;
        got_done = s_done;
        while (lat < 200 && !got_done) begin
            @(negedge clk);
            lat++;
            got_done = s_done;
        end
        check({tag, "_done"}, 64'(got_done), 64'(1));
        check({tag, "_err"}, 64'(s_err), 64'(exp_err));
        if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        lat = 0;
        while (lat < 200 && !(s_in_ready && q_s.size() == 0 && !s_out_valid)) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_drained"}, 64'(q_s.size()), 64'(0));
        check({tag, "_idle"}, 64'({s_in_ready, s_busy}), 64'(2'b10));
        if (exp_err) check({tag, "_no_ov"}, 64'(s_ov_seen), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [LOP-1:0] p256, r256;
        logic [LOP:0]   tmp;
        int             lat;
        int             primes[4] = '{251, 4093, 32749, 65521};
        rst = 1'b1;
        s_in_valid = 1'b0; s_in_sel = 2'd0; s_in_data = '0; s_mode = 1'b0; s_start = 1'b0;
        l_in_valid = 1'b0; l_in_sel = 2'd0; l_in_data = '0; l_mode = 1'b0; l_start = 1'b0;
        l_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_outs", 64'({s_in_ready, s_busy, s_done, s_err, s_out_valid, s_out_last, s_out_data}),
              64'({1'b1, 5'b0, 8'h00}));
        check("rst_l_outs", 64'({l_in_ready, l_busy, l_done, l_err, l_out_valid, l_out_last}), 64'(6'b100000));
        rst = 1'b0;
        @(posedge clk); #1;

        run_s("inv13_3", 1'b1, 3, 0, 13, 1'b0, 0);
        run_s("div13_3_5", 1'b0, 3, 5, 13, 1'b0, 0);
        run_s("div15_7_4", 1'b0, 7, 4, 15, 1'b0, 0);
        s_rdy_mode = 1;
        run_s("bp_inv", 1'b1, 12345, 0, 65521, 1'b0, 0);
        run_s("bp_div", 1'b0, 40000, 777, 65521, 1'b0, 0);
        s_rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            int p;
            p = primes[i % 4];
            run_s("rand", 1'($urandom_range(0, 1)), int'($urandom_range(1, p - 1)),
                  int'($urandom_range(0, p - 1)), p, 1'b0, 0);
        end
        run_s("err15_6", 1'b1, 6, 0, 15, 1'b1, 0);
        run_s("err_p_even", 1'b1, 3, 0, 14, 1'b1, 2);
        run_s("err_a_zero", 1'b1, 0, 0, 13, 1'b1, 2);
        run_s("err_a_ge_p", 1'b0, 13, 2, 13, 1'b1, 2);
        run_s("err_p_small", 1'b1, 1, 0, 1, 1'b1, 2);

        // Abort mid-RUN with reset, then rerun from a fresh load.
        start_s("rst_run", 1'b1, 40000, 0, 65521);
        repeat (3) @(posedge clk);
        #1;
        check("rst_run_busy", 64'(s_busy), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_run_outs", 64'({s_in_ready, s_busy, s_done, s_err, s_out_valid, s_out_last, s_out_data}),
              64'({1'b1, 5'b0, 8'h00}));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_s("after_rst", 1'b1, 40000, 0, 65521, 1'b0, 0);

        // P-256: 2^-1 mod p = (p+1)/2.
        p256 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
        tmp  = {1'b0, p256} + 257'd1;
        r256 = tmp[LOP:1];
        for (int w = 0; w < int'(LNW); w++)
            q_l.push_back('{data: r256[w*LW +: LW], last: (w == int'(LNW) - 1)});
        load_l(2'd0, 256'd2);
        load_l(2'd2, p256);
        l_mode = 1'b1; l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        lat = 0;
        while (lat < 3000 && !l_done) begin @(negedge clk); lat++; end
        check("p256_done", 64'(l_done), 64'(1));
        check("p256_err", 64'(l_err), 64'(0));
        lat = 0;
        while (lat < 100 && !(l_in_ready && q_l.size() == 0)) begin @(negedge clk); lat++; end
        check("p256_drained", 64'(q_l.size()), 64'(0));
        @(posedge clk); #1;

`ifdef MINV_MDIV_GEN_WDOG_EN
        // Pin u even so RUN never terminates; the watchdog must fire.
        force dut_s.u_q = 16'd2;
        start_s("wdog", 1'b1, 3, 0, 13);
        lat = 1;
        while (lat < 300 && !s_done) begin @(negedge clk); lat++; end
        check("wdog_lat", 64'(lat), 64'(4 * SOP + 3 + 2));
        check("wdog_err", 64'(s_err), 64'(1));
        release dut_s.u_q;
        @(posedge clk); #1;
        run_s("post_wdog", 1'b1, 3, 0, 13, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/minv_mdiv_gen.md
# minv_mdiv_gen

Parametrised modular inverse / modular division engine, the width-generic successor of the fixed 256-bit/32-bit engine. It computes a⁻¹ mod p (inverse mode) or b·a⁻¹ mod p (division mode) with the binary extended Euclidean algorithm, one datapath action per cycle. Operands are loaded word-serially over a valid/ready bus. The result is streamed out the same way with a last-word marker. Unlike its predecessor, it detects non-invertible or illegal operands and reports `err` instead of hanging.

## Interface
- `OPW`, 256, operand/result width in bits; must be a multiple of `BUSW`.
- `BUSW`, 32, load/unload bus width; `NW = OPW/BUSW` words per operand.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  load word valid.
- `in_ready`  out  1  high only in IDLE.
- `in_sel`  in  2  target register: 00=a, 01=b, 10=p, 11=ignored (beat accepted, discarded).
- `in_data`  in  BUSW  load word, least-significant word first.
- `mode`  in  1  1=inverse, 0=division; sampled on `start`.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `busy`  out  1  high from the cycle after start until return to IDLE.
- `done`  out  1  one-cycle pulse at end of computation, success or error.
- `err`  out  1  sticky error flag; valid with `done`; cleared on next start.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  BUSW  result word, least-significant first.
- `out_last`  out  1  high with word NW-1.

## Operation
- Load: each accepted beat (`in_valid & in_ready`) right-shifts the selected OPW register by BUSW and inserts `in_data` at the top. After NW beats the operand is fully loaded. Registers hold their values across runs.
- States: IDLE → CHECK → RUN → (OUT | IDLE).
- CHECK (1 cycle), with u=a, v=p, x1=(mode ? 1 : b), x2=0:
  - If p even, p<3, a==0, or a≥p: set err and go to IDLE with `done`.
  - Otherwise go to RUN.
- RUN: one action per cycle, evaluated in priority order:
  1. If u==1: result=x1, go to OUT.
  2. If v==1: result=x2, go to OUT.
  3. If u==0 or v==0: set err, go to IDLE.
  4. If u even: u>>=1; x1 = x1 even ? x1>>1 : (x1+p)>>1. The sum is OPW+1 bits and its carry becomes the new MSB.
  5. If v even: same step on v/x2.
  6. If u≥v: u-=v; x1=x1-x2, adding p if it borrows.
  7. Otherwise: v-=u; x2=x2-x1, adding p if it borrows.
- x1 and x2 stay in [0,p) throughout.
- `done` pulses on the cycle leaving RUN or CHECK.
- OUT: `result` is unloaded LS word first. A word advances only on `out_valid & out_ready`. After the beat with `out_last`, go to IDLE.
- `start` outside IDLE is ignored. `in_valid` outside IDLE is not accepted.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `done`=0, `err`=0, `out_valid`=0, `out_last`=0, `out_data`=0. State=IDLE and all registers zero.
- Reset asserted mid-run or mid-unload aborts immediately to IDLE. Loaded operands are lost.
- Latency from start to done = 1 (CHECK) + number of RUN actions + 1. For valid inputs, RUN actions ≤ 4·OPW+2.
- `out_valid` rises the cycle after `done`. With `out_ready` held high, unload takes NW cycles.
- `out_data` and `out_last` are stable while `out_valid & !out_ready`.
- IDLE is reached the cycle after the last beat, so `in_ready` is 1 on that cycle.

## Configuration
- `MINV_MDIV_GEN_WDOG_EN` defined: a RUN-cycle counter of width clog2(4·OPW+4) is compiled in. If it reaches 4·OPW+3 while in RUN, the engine sets err, pulses `done`, and returns to IDLE. This guards against corrupted state.
- Not defined: no counter. Termination relies only on the CHECK rules and the zero-detection rule.

## Test plan
(Config OPW=16, BUSW=8, plus one OPW=256, BUSW=32 run.)
- Inverse, p=13, a=3 → done, err=0. Two words are output: 0x09 then 0x00, with out_last on the second.
- Division, p=13, a=3, b=5 → result 6. Same case at 256 bits with P-256 prime p, a=2 → result (p+1)/2, with 8 output words.
- p=15, a=6 → err=1, out_valid never asserted. Separately: p=14 and a=0 each give err on the cycle after CHECK, with done 2 cycles after start.
- Backpressure: toggle `out_ready` 1/0 each cycle during unload → words are in order with no duplicates or drops, and `out_data` is held while stalled.
- Assert `rst` during RUN → all outputs return to reset values in the same cycle. A fresh load and start then produces the correct result.
- With `MINV_MDIV_GEN_WDOG_EN`, force u stuck even through a hierarchical deposit → err and done at exactly 4·OPW+3 RUN cycles.
